// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signal bundle for icache_assoc.
// The slave modport is the cache. The master modport is the datapath and memory side that drives it.
interface icache_assoc_if;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport master (
        output halt, imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

    modport slave (
        input  halt, imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word blocks and LRU replacement.
// On a miss, a refill FSM fetches the whole block one word at a time.
// The line is written only after its last word arrives.
module icache_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input logic          CLK,
    input logic          nRST,
    icache_assoc_if.slave bus
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int K_W   = (WORDS > 1) ? OFF_W : 1;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] REFILL = 1'b1;

    logic [0:0]       state;
    logic [K_W-1:0]   k;
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;
    logic [31:0]      fill_buf [WORDS];

    logic             valid    [WAYS][SETS];
    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [31:0]      data_mem [WAYS][SETS][WORDS];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [K_W-1:0]   req_off;
    logic [31:0]      refill_addr;

    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] lru_way;
    logic             inv_found;

    logic lookup_en, hit_now, miss_now, capture, last_word, line_wr;

    assign req_tag = bus.imemaddr[31 -: TAG_W];
    assign req_idx = bus.imemaddr[2 + OFF_W +: IDX_W];

    generate
        if (WORDS > 1) begin : g_multi_word
            assign req_off     = bus.imemaddr[2 +: OFF_W];
            assign refill_addr = {miss_tag, miss_idx, k, 2'b00};
        end else begin : g_single_word
            assign req_off     = '0;
            assign refill_addr = {miss_tag, miss_idx, 2'b00};
        end
    endgenerate

    assign lookup_en = (state == IDLE) && !bus.halt && bus.imemREN;
    assign hit_now   = lookup_en && hit_any;
    assign miss_now  = lookup_en && !hit_any;
    assign capture   = (state == REFILL) && !bus.halt && !bus.iwait;
    assign last_word = (k == K_W'(WORDS - 1));
    assign line_wr   = capture && last_word;

    assign bus.ihit     = hit_now;
    assign bus.imemload = hit_now ? data_mem[hit_way][req_idx][req_off] : '0;
    assign bus.iREN     = (state == REFILL) && !bus.halt;
    assign bus.iaddr    = bus.iREN ? refill_addr : '0;

    // Tag lookup in the requested set; the first matching valid way wins
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit_any && valid[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim choice: the lowest invalid way; if none is invalid, the least recently used way
    always_comb begin
        inv_found = 1'b0;
        victim    = lru_way;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!inv_found && !valid[w][miss_idx]) begin
                inv_found = 1'b1;
                victim    = WAY_W'(w);
            end
        end
    end

    // Refill FSM: state, fill counter, latched miss address, and valid bits
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            k        <= '0;
            miss_tag <= '0;
            miss_idx <= '0;
            for (int unsigned w = 0; w < WAYS; w++)
                for (int unsigned s = 0; s < SETS; s++)
                    valid[w][s] <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_now) begin
                        miss_tag <= req_tag;
                        miss_idx <= req_idx;
                        k        <= '0;
                        state    <= REFILL;
                    end
                end
                default: begin
                    if (bus.halt) begin
                        state <= IDLE;
                    end else if (!bus.iwait) begin
                        k <= last_word ? '0 : k + 1'b1;
                        if (last_word) begin
                            valid[victim][miss_idx] <= 1'b1;
                            state                   <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Fill buffer capture and line write; the final word goes straight from iload into the line
    always_ff @(posedge CLK) begin
        if (capture)
            fill_buf[k] <= bus.iload;
        if (line_wr) begin
            tag_mem[victim][miss_idx] <= miss_tag;
            for (int unsigned j = 0; j < WORDS; j++)
                data_mem[victim][miss_idx][j] <= (j == WORDS - 1) ? bus.iload : fill_buf[j];
        end
    end

    generate
        if (WAYS > 1) begin : g_lru
            logic [WAY_W-1:0] age [WAYS][SETS];
            logic             upd_en;
            logic [WAY_W-1:0] upd_way;
            logic [IDX_W-1:0] upd_idx;

            assign upd_en  = hit_now || line_wr;
            assign upd_way = hit_now ? hit_way : victim;
            assign upd_idx = hit_now ? req_idx : miss_idx;

            // The oldest way in the missing set has age WAYS-1
            always_comb begin
                lru_way = '0;
                for (int unsigned w = 0; w < WAYS; w++)
                    if (age[w][miss_idx] == WAY_W'(WAYS - 1))
                        lru_way = WAY_W'(w);
            end

            // Age update: the touched way becomes 0, and every way younger than it ages by one
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    for (int unsigned w = 0; w < WAYS; w++)
                        for (int unsigned s = 0; s < SETS; s++)
                            age[w][s] <= WAY_W'(w);
                end else if (upd_en) begin
                    for (int unsigned w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == upd_way)
                            age[w][upd_idx] <= '0;
                        else if (age[w][upd_idx] < age[upd_way][upd_idx])
                            age[w][upd_idx] <= age[w][upd_idx] + 1'b1;
                    end
                end
            end
        end else begin : g_direct
            assign lru_way = '0;
        end
    endgenerate
endmodule
